// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per ADJUST/SHIFT pair.
// Result and overflow flag are registered at FINISH and held until the next result or reset.
module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  overflow
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, FINISH} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  shreg_reg, shreg_next;
  logic [SW-1:0]     scratch_reg, scratch_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              sticky_reg, sticky_next;
  logic [SW-1:0]     bcd_reg, bcd_next;
  logic              overflow_reg, overflow_next;
  logic              done_reg, done_next;
  logic [SW-1:0]     adjusted;

  // Digits are corrected independently; a digit >= 5 can never carry into its neighbour.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
    assign adjusted[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                 scratch_reg[4*gi +: 4] + 4'd3 :
                                 scratch_reg[4*gi +: 4];
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      sticky_reg   <= 1'b0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      scratch_reg  <= scratch_next;
      cnt_reg      <= cnt_next;
      sticky_reg   <= sticky_next;
      bcd_reg      <= bcd_next;
      overflow_reg <= overflow_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    scratch_next  = scratch_reg;
    cnt_next      = cnt_reg;
    sticky_next   = sticky_reg;
    bcd_next      = bcd_reg;
    overflow_next = overflow_reg;
    done_next     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          shreg_next   = binary;
          scratch_next = '0;
          cnt_next     = CW'(WIDTH);
          sticky_next  = 1'b0;
          state_next   = ADJUST;
        end
      end
      ADJUST: begin
        scratch_next = adjusted;
        state_next   = SHIFT;
      end
      SHIFT: begin
        // Any bit pushed out of the top digit means the value needs more digits than we have.
        {scratch_next, shreg_next} = {scratch_reg[SW-2:0], shreg_reg, 1'b0};
        sticky_next = sticky_reg | scratch_reg[SW-1];
        cnt_next    = cnt_reg - CW'(1);
        state_next  = (cnt_reg == CW'(1)) ? FINISH : ADJUST;
      end
      FINISH: begin
        bcd_next      = scratch_reg;
        overflow_next = sticky_reg;
        done_next     = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign BCD      = bcd_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: three parameterisations, directed cases plus a random
// run on the default instance checked every cycle against a behavioural model.
module tb_bcd_seq_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start0;  logic [7:0] bin0;  logic busy0, done0;  logic [11:0] bcd0;  logic ovf0;
  logic        start1;  logic [3:0] bin1;  logic busy1, done1;  logic [7:0]  bcd1;  logic ovf1;
  logic        start2;  logic [7:0] bin2;  logic busy2, done2;  logic [7:0]  bcd2;  logic ovf2;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u0 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start0), .binary(bin0),
    .busy(busy0), .done(done0), .BCD(bcd0), .overflow(ovf0));
  bcd_seq_converter #(.WIDTH(4), .DIGITS(2)) u1 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start1), .binary(bin1),
    .busy(busy1), .done(done1), .BCD(bcd1), .overflow(ovf1));
  bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) u2 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .start(start2), .binary(bin2),
    .busy(busy2), .done(done2), .BCD(bcd2), .overflow(ovf2));

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v, least significant first, truncated to the given digit count.
  function automatic logic [63:0] to_bcd(input longint unsigned v, input int digits);
    logic [63:0] r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic too_big(input longint unsigned v, input int digits);
    for (int i = 0; i < digits; i++) v = v / 10;
    return v != 0;
  endfunction

  // Reference for u0: a result appears 17 cycles after acceptance; starts are only
  // taken when no conversion is outstanding.
  int          rem_m = 0;
  logic [7:0]  val_m = '0;
  logic [11:0] bcd_m = '0;
  logic        ovf_m = 1'b0;
  logic        done_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_m  <= 0;
      bcd_m  <= '0;
      ovf_m  <= 1'b0;
      done_m <= 1'b0;
    end else begin
      done_m <= 1'b0;
      if (rem_m > 0) begin
        rem_m <= rem_m - 1;
        if (rem_m == 1) begin
          bcd_m  <= 12'(to_bcd(val_m, 3));
          ovf_m  <= too_big(val_m, 3);
          done_m <= 1'b1;
        end
      end else if (start0) begin
        val_m <= bin0;
        rem_m <= 17;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("u0_busy", busy0, rem_m != 0);
      chk("u0_done", done0, done_m);
      chk("u0_bcd",  bcd0,  bcd_m);
      chk("u0_ovf",  ovf0,  ovf_m);
    end
  end

  task automatic go0(input logic [7:0] v, output int cyc);
    @(negedge clk); start0 = 1'b1; bin0 = v;
    @(negedge clk); start0 = 1'b0; bin0 = 8'($urandom);
    cyc = 1;
    while (!done0 && cyc < 40) begin @(negedge clk); cyc++; end
    if (!done0) begin n_cmp++; n_bad++; $display("FAIL u0_timeout: no done after %0d cycles", cyc); end
  endtask

  task automatic go1(input logic [3:0] v, output int cyc);
    @(negedge clk); start1 = 1'b1; bin1 = v;
    @(negedge clk); start1 = 1'b0; bin1 = 4'($urandom);
    cyc = 1;
    while (!done1 && cyc < 40) begin @(negedge clk); cyc++; end
    if (!done1) begin n_cmp++; n_bad++; $display("FAIL u1_timeout: no done after %0d cycles", cyc); end
  endtask

  task automatic go2(input logic [7:0] v, output int cyc);
    @(negedge clk); start2 = 1'b1; bin2 = v;
    @(negedge clk); start2 = 1'b0; bin2 = 8'($urandom);
    cyc = 1;
    while (!done2 && cyc < 40) begin @(negedge clk); cyc++; end
    if (!done2) begin n_cmp++; n_bad++; $display("FAIL u2_timeout: no done after %0d cycles", cyc); end
  endtask

  logic [3:0] sweep_in  [5] = '{4'd10, 4'd4, 4'd11, 4'd14, 4'd15};
  logic [7:0] sweep_exp [5] = '{8'h10, 8'h04, 8'h11, 8'h14, 8'h15};

  initial begin
    int cyc;
    int ndone;
    rst_n = 1'b0;
    start0 = 1'b0; bin0 = '0;
    start1 = 1'b0; bin1 = '0;
    start2 = 1'b0; bin2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_bcd",  bcd0,  12'h000);
    chk("rst_ovf",  ovf0,  1'b0);
    chk("rst_bcd_u2", bcd2, 8'h00);
    checking = 1'b1;
    #1 rst_n = 1'b1;

    // 255 -> 255, done seen 18 negedges after the drive negedge (latency 17)
    go0(8'hFF, cyc);
    chk("t1_lat", cyc, 18);
    chk("t1_bcd", bcd0, 12'h255);
    chk("t1_ovf", ovf0, 1'b0);
    chk("t1_model", bcd_m, 12'h255);
    $display("t1 bin=255 bcd=%h ovf=%b cycles=%0d", bcd0, ovf0, cyc);

    // Back-to-back with start held: second accepted in the first done cycle.
    @(negedge clk); start0 = 1'b1; bin0 = 8'd0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done0 && cyc < 40);
    chk("t2_first_done", done0, 1'b1);
    chk("t2_bcd0", bcd0, 12'h000);
    bin0 = 8'd10;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin start0 = 1'b0; bin0 = 8'd99; end
    end while (!done0 && cyc < 40);
    chk("t2_gap", cyc, 18);
    chk("t2_bcd10", bcd0, 12'h010);
    chk("t2_model", bcd_m, 12'h010);
    $display("t2 second bcd=%h gap=%0d", bcd0, cyc);

    // WIDTH=4, DIGITS=2 sweep with latency check
    for (int i = 0; i < 5; i++) begin
      go1(sweep_in[i], cyc);
      chk("t3_lat", cyc, 10);
      chk("t3_bcd", bcd1, sweep_exp[i]);
      chk("t3_ovf", ovf1, 1'b0);
      $display("t3 bin=%0d bcd=%h cycles=%0d", sweep_in[i], bcd1, cyc);
    end
    for (int v = 0; v < 16; v++) begin
      go1(4'(v), cyc);
      chk("t3_all_bcd", bcd1, 8'(to_bcd(v, 2)));
      chk("t3_all_ovf", ovf1, too_big(v, 2));
    end

    // Request and operand changes while busy are ignored.
    @(negedge clk); start0 = 1'b1; bin0 = 8'd200;
    @(negedge clk); bin0 = 8'd7;
    ndone = 0;
    cyc = 1;
    while (!done0 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (cyc == 6) start0 = 1'b0;
    end
    chk("t4_bcd", bcd0, 12'h200);
    repeat (25) begin @(negedge clk); if (done0) ndone++; end
    chk("t4_extra_done", ndone, 0);
    chk("t4_hold", bcd0, 12'h200);
    $display("t4 bcd=%h extra_done=%0d", bcd0, ndone);

    // WIDTH=8, DIGITS=2 overflow
    go2(8'd123, cyc);
    chk("t5_bcd123", bcd2, 8'h23);
    chk("t5_ovf123", ovf2, 1'b1);
    $display("t5 bin=123 bcd=%h ovf=%b", bcd2, ovf2);
    go2(8'd99, cyc);
    chk("t5_bcd99", bcd2, 8'h99);
    chk("t5_ovf99", ovf2, 1'b0);
    $display("t5 bin=99 bcd=%h ovf=%b", bcd2, ovf2);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      go2(v, cyc);
      chk("t5_rnd_bcd", bcd2, 8'(to_bcd(v, 2)));
      chk("t5_rnd_ovf", ovf2, too_big(v, 2));
      $display("t5 bin=%0d bcd=%h ovf=%b", v, bcd2, ovf2);
    end

    // Reset mid-conversion: outputs clear at once, aborted conversion never completes.
    @(negedge clk); start0 = 1'b1; bin0 = 8'd77;
    @(negedge clk); start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy0, 1'b0);
    chk("t6_bcd",  bcd0,  12'h000);
    chk("t6_ovf",  ovf0,  1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin @(negedge clk); if (done0) ndone++; end
    chk("t6_no_done", ndone, 0);
    go0(8'd42, cyc);
    chk("t6_after_bcd", bcd0, 12'h042);
    chk("t6_after_lat", cyc, 18);
    $display("t6 post-reset bcd=%h cycles=%0d", bcd0, cyc);

    // Random traffic on u0, occasional asynchronous resets; model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start0 = ($urandom_range(3) == 0);
      bin0   = 8'($urandom);
      if (done0) $display("rnd result bcd=%h ovf=%b", bcd0, ovf0);
      if ($urandom_range(400) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    start0 = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Multi-cycle binary-to-BCD converter controller using the shift-and-add-3 (double-dabble) algorithm with a start/busy/done handshake. It replaces a wide combinational converter on the ALU result path, so that wide results meet 100 MHz timing ahead of the 7-segment display driver. One conversion is in flight at a time. The operand is captured at acceptance.

Parameters:
WIDTH, 8, bit width of the binary input (>=1)
DIGITS, 3, number of BCD output digits (>=1)

Ports:
CLK100MHZ  input  1  system clock; all state changes on the rising edge
CPU_RESETN  input  1  asynchronous, active-low reset
start  input  1  conversion request; sampled only in IDLE
binary  input  WIDTH  unsigned operand; captured on the accepting edge only
busy  output  1  high while a conversion is in progress (state != IDLE)
done  output  1  one-cycle completion pulse (registered)
BCD  output  4*DIGITS  result; digit i occupies BCD[4i+3:4i], digit 0 is ones
overflow  output  1  value >= 10^DIGITS; valid with done, held with BCD

Behaviour:
- Reset (CPU_RESETN=0, asynchronous, at any time including mid-conversion):
  - state=IDLE; busy=0, done=0, BCD=0, overflow=0.
  - Internal shift register, scratch, counter and sticky flag are cleared.
  - No done pulse is produced for the aborted conversion.
- States: IDLE, ADJUST, SHIFT, FINISH.
- IDLE: if start=1 on edge k:
  - shreg<=binary, scratch<=0, cnt<=WIDTH, sticky<=0, state<=ADJUST.
  - Otherwise remain in IDLE.
- ADJUST (1 cycle):
  - Each 4-bit scratch digit >=5 gets +3. Adjust is per digit with no carry between digits.
  - state<=SHIFT.
- SHIFT (1 cycle):
  - {scratch,shreg} shifts left by 1. The bit leaving scratch MSB is ORed into sticky.
  - cnt<=cnt-1.
  - If cnt==1, state<=FINISH; else state<=ADJUST.
- FINISH (1 cycle):
  - BCD<=scratch, overflow<=sticky, done<=1, state<=IDLE.
- done is 1 only in the cycle after FINISH. It is cleared on the next edge.
- Timing, relative to accepting edge k:
  - busy is high for the 2*WIDTH+1 cycles following edge k.
  - BCD, overflow and done update on edge k+2*WIDTH+1.
  - Latency is 2*WIDTH+1 cycles.
- BCD and overflow hold their values until the next FINISH or reset.
  - They do not change when a new conversion starts.
- start while busy=1 is ignored: no queueing, no effect on the running conversion.
- Changes on binary after the accepting edge have no effect.
- Back-to-back operation:
  - start is accepted in the cycle done=1, since the state is then IDLE.
  - Minimum accept-to-accept period is 2*WIDTH+2 cycles.
- Overflow case:
  - BCD holds value mod 10^DIGITS, with correct lower digits; overflow=1.
  - Overflow never occurs when 10^DIGITS > 2^WIDTH (e.g. defaults).
- Arithmetic: unsigned only. Scratch width is 4*DIGITS; cnt width is clog2(WIDTH+1).

Test Plan:
1. Default params, binary=8'hFF, start pulse at edge k -> busy high edges k..k+16; done pulse after edge k+17; BCD=12'h255, overflow=0.
2. binary=0, then binary=8'd10 back-to-back with start held high -> BCD=12'h000 with first done; second accepted in the first done cycle; BCD=12'h010 exactly 18 cycles after the first done.
3. WIDTH=4, DIGITS=2, binary sweep 4'b1010, 4'b0100, 4'b1011, 4'b1110, 4'b1111 -> BCD=8'h10, 8'h04, 8'h11, 8'h14, 8'h15; latency 9 each.
4. Default params, start and binary=8'd200, then start=1 with binary=8'd7 during busy -> single done; BCD=12'h200; second request dropped; binary change ignored.
5. WIDTH=8, DIGITS=2, binary=8'd123 -> BCD=8'h23, overflow=1. Then binary=8'd99 -> BCD=8'h99, overflow=0.
6. Deassert CPU_RESETN mid-conversion (edge k+5), release, check 30 cycles -> immediate busy=0, BCD=0, overflow=0; no done ever pulses; next start converts normally.
